// File: rtl/pdm_record_buffer.sv
// Record/playback buffer for deserialized PDM words: captures words while recording, streams them back out while playing.
// Define PDM_RECORD_BUFFER_LOOP_EN to make playback wrap to word 0 until play drops.
module pdm_record_buffer #(
  parameter int DEPTH_LOG2 = 10,
  parameter int WIDTH      = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  record,
  input  logic                  play,
  input  logic                  word_valid,
  input  logic [WIDTH-1:0]      word_in,
  input  logic                  rd_ready,
  output logic [WIDTH-1:0]      word_out,
  output logic                  word_out_valid,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic [1:0]            state
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'b00, RECORD = 2'b01, PLAY = 2'b10} state_t;
  typedef enum logic [1:0] {FETCH, LOAD, SHOW} phase_t;

  state_t                state_q, state_d;
  phase_t                phase_q, phase_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2-1:0] raddr;
  logic [WIDTH-1:0]      rd_data_q;
  logic [WIDTH-1:0]      word_out_q, word_out_d;
  logic                  valid_q, valid_d;
  logic                  wv_q, rec_q, play_q;
  logic                  we, re;
  logic                  wv_rise, rec_rise, play_rise, last;
  logic [WIDTH-1:0]      mem [0:DEPTH-1];

  assign wv_rise   = word_valid & ~wv_q;
  assign rec_rise  = record & ~rec_q;
  assign play_rise = play & ~play_q;
  assign last      = ({1'b0, rd_ptr_q} == (count_q - 1'b1));

  // Playback runs FETCH (RAM read) -> LOAD (present) -> SHOW (hold until taken);
  // a transfer prefetches the next word so valid drops for exactly one cycle.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    word_out_d = word_out_q;
    valid_d    = valid_q;
    we         = 1'b0;
    re         = 1'b0;
    raddr      = rd_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (rec_rise) begin
          state_d  = RECORD;
          count_d  = '0;
          wr_ptr_d = '0;
        end else if (play_rise && (count_q != '0)) begin
          state_d  = PLAY;
          phase_d  = FETCH;
          rd_ptr_d = '0;
        end
      end
      RECORD: begin
        if (!record) begin
          state_d = IDLE;
        end else if (wv_rise) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          count_d  = count_q + 1'b1;
          if (count_q == (DEPTH_CNT - 1'b1)) state_d = IDLE;
        end
      end
      PLAY: begin
        if (!play) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else begin
          unique case (phase_q)
            FETCH: begin
              re      = 1'b1;
              phase_d = LOAD;
            end
            LOAD: begin
              word_out_d = rd_data_q;
              valid_d    = 1'b1;
              phase_d    = SHOW;
            end
            SHOW: begin
              if (rd_ready) begin
                valid_d = 1'b0;
                if (last) begin
`ifdef PDM_RECORD_BUFFER_LOOP_EN
                  rd_ptr_d = '0;
                  raddr    = '0;
                  re       = 1'b1;
                  phase_d  = LOAD;
`else
                  state_d  = IDLE;
`endif
                end else begin
                  rd_ptr_d = rd_ptr_q + 1'b1;
                  raddr    = rd_ptr_q + 1'b1;
                  re       = 1'b1;
                  phase_d  = LOAD;
                end
              end
            end
            default: phase_d = FETCH;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      phase_q    <= FETCH;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      word_out_q <= '0;
      valid_q    <= 1'b0;
      wv_q       <= 1'b1;
      rec_q      <= 1'b1;
      play_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      word_out_q <= word_out_d;
      valid_q    <= valid_d;
      wv_q       <= word_valid;
      rec_q      <= record;
      play_q     <= play;
    end
  end

  always_ff @(posedge clock) begin
    if (reset_n && we) mem[wr_ptr_q] <= word_in;
    if (reset_n && re) rd_data_q <= mem[raddr];
  end

  assign word_out       = word_out_q;
  assign word_out_valid = valid_q;
  assign count          = count_q;
  assign full           = (count_q == DEPTH_CNT);
  assign empty          = (count_q == '0);
  assign state          = state_q;

endmodule

// File: doc/pdm_record_buffer.md
PDM_RECORD_BUFFER -- requirements
Module: pdm_record_buffer

Interface
REQ-001 Parameter DEPTH_LOG2, default 10, log2 of buffer depth in 16-bit words.
REQ-002 Parameter WIDTH, default 16, word width; matches the deserializer data output.
REQ-003 clock  input  1  system clock, 100 MHz, shared with the deserializer.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 record  input  1  record request level; recording starts on its rising edge.
REQ-006 play  input  1  playback request level; playback starts on its rising edge.
REQ-007 word_valid  input  1  deserializer done strobe; may be held high while the deserializer is disabled.
REQ-008 word_in  input  WIDTH  deserializer data word.
REQ-009 rd_ready  input  1  downstream consumer accepts word_out this cycle.
REQ-010 word_out  output  WIDTH  playback word.
REQ-011 word_out_valid  output  1  word_out holds a valid word.
REQ-012 count  output  DEPTH_LOG2+1  number of words recorded.
REQ-013 full  output  1  count equals 2^DEPTH_LOG2.
REQ-014 empty  output  1  count equals 0.
REQ-015 state  output  2  current state: 00 IDLE, 01 RECORD, 10 PLAY.

Function
REQ-016 The block SHALL register word_valid, record and play every cycle and detect rising edges as current=1 with previous=0.
REQ-017 In IDLE, a record rising edge SHALL enter RECORD and clear count and the write pointer to 0 in the same edge.
REQ-018 In IDLE, a play rising edge with count!=0 SHALL enter PLAY and clear the read pointer; a play edge with count==0 SHALL be ignored.
REQ-019 If record and play rising edges occur in the same cycle in IDLE, record SHALL win.
REQ-020 In RECORD, each word_valid rising edge SHALL write word_in at the write pointer, then increment the write pointer and count.
REQ-021 A word_valid level held high without a new edge SHALL NOT write.
REQ-022 RECORD SHALL return to IDLE when record is low, or on the edge that makes count reach 2^DEPTH_LOG2; no further writes occur.
REQ-023 In PLAY, the buffer SHALL use a synchronous read with 1-cycle latency.
REQ-024 word_out_valid SHALL first assert 2 cycles after the edge at which the play rising edge is sampled.
REQ-025 A transfer SHALL occur on each edge where word_out_valid=1 and rd_ready=1.
REQ-026 After each transfer, word_out_valid SHALL be low for exactly 1 cycle, then high with the next word; word_out and word_out_valid SHALL hold stable while rd_ready=0.
REQ-027 PLAY SHALL return to IDLE on the transfer of word index count-1, or when play is low; word_out_valid SHALL be 0 in IDLE and RECORD.
REQ-028 record and play edges during PLAY and RECORD respectively SHALL be ignored.
REQ-029 Recorded contents and count SHALL persist across PLAY and IDLE until the next RECORD entry.

Reset
REQ-030 reset_n=0 at a clock edge SHALL force state=IDLE, count=0, pointers=0, word_out=0, word_out_valid=0, full=0, empty=1.
REQ-031 Reset SHALL set the previous-value registers for word_valid, record and play to 1, so levels already high at reset release are not edges.
REQ-032 Reset asserted mid-RECORD or mid-PLAY SHALL abort immediately; buffer RAM contents need not be cleared.

Configuration
REQ-033 Macro PDM_RECORD_BUFFER_LOOP_EN, when defined: in PLAY, transfer of word count-1 SHALL wrap the read pointer to 0 and continue; exit is only by play low.
REQ-034 When PDM_RECORD_BUFFER_LOOP_EN is undefined, behaviour SHALL be exactly as in REQ-027.

Verification (DEPTH_LOG2=2 bench build)
REQ-035 Reset, then record high, three word_valid pulses with data 0x1111/0x2222/0x3333, then record low -> count=3, state=IDLE, empty=0.
REQ-036 word_valid held high for 40 cycles in RECORD -> exactly 1 word written, count=1.
REQ-037 Five word_valid pulses with record held high -> count=4, full=1, state=IDLE after the 4th pulse; the 5th word is not stored.
REQ-038 After REQ-035, play edge with rd_ready=1 -> outputs 0x1111, 0x2222, 0x3333 with one-cycle valid gaps, then IDLE; with loop macro defined, 0x1111 follows again.
REQ-039 rd_ready=0 for 10 cycles in PLAY -> word_out stable at the current word; reset_n=0 mid-PLAY -> word_out_valid=0 and state=IDLE next cycle.
REQ-040 Record and play edges in the same cycle from IDLE -> state=RECORD; a play edge with count=0 -> stays IDLE.
